// File: rtl/mux_arb.sv
// N-channel valid/ready multiplexer with one registered output stage.
// The grant comes from an explicit select or from a round-robin scan, chosen at run time by mode.
module mux_arb #(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0]    r_data;
    logic [SEL_W-1:0]    r_chan;
    logic                r_valid;
    logic [SEL_W-1:0]    r_ptr;

    logic                w_load;
    logic                w_grant;
    logic [SEL_W-1:0]    w_g;
    logic [SEL_W:0]      w_idx;
    logic [WIDTH-1:0]    w_data;
    logic [SEL_W-1:0]    w_ptr_next;
    logic [CHANNELS-1:0] w_ready;

    assign w_load = !r_valid || out_ready;

    // Grant decision; the scan runs backwards so the lowest offset from r_ptr wins.
    always_comb begin
        w_grant = 1'b0;
        w_g     = '0;
        w_idx   = '0;
        if (rst) begin
            w_grant = 1'b0;
        end else if (mode) begin
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                w_idx = {1'b0, r_ptr} + (SEL_W+1)'(i);
                if (w_idx >= (SEL_W+1)'(CHANNELS)) begin
                    w_idx = w_idx - (SEL_W+1)'(CHANNELS);
                end else begin
                    w_idx = w_idx;
                end
                if (in_valid[w_idx[SEL_W-1:0]]) begin
                    w_grant = 1'b1;
                    w_g     = w_idx[SEL_W-1:0];
                end else begin
                    w_grant = w_grant;
                end
            end
        end else if ((32'(sel) < CHANNELS) && in_valid[sel]) begin
            w_grant = 1'b1;
            w_g     = sel;
        end else begin
            w_grant = 1'b0;
        end
    end

    // Data mux for the granted channel, plus per-channel ready decode.
    always_comb begin
        w_data  = '0;
        w_ready = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_g == SEL_W'(k)) begin
                w_data     = in_data[k*WIDTH +: WIDTH];
                w_ready[k] = w_load && w_grant;
            end else begin
                w_ready[k] = 1'b0;
            end
        end
    end

    // Next pointer wraps explicitly so non-power-of-two channel counts work.
    always_comb begin
        if (w_g == SEL_W'(CHANNELS - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_g + SEL_W'(1);
        end
    end

    assign in_ready = w_ready;

    // Output stage and fairness pointer; a grant implies the granted channel is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_chan  <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else if (w_load) begin
            if (w_grant) begin
                r_data  <= w_data;
                r_chan  <= w_g;
                r_valid <= 1'b1;
                r_ptr   <= w_ptr_next;
            end else begin
                r_valid <= 1'b0;
            end
        end else begin
            r_valid <= r_valid;
        end
    end

    assign out_data  = r_data;
    assign out_chan  = r_chan;
    assign out_valid = r_valid;

endmodule
